// File: rtl/tile_out_collector_if.sv
// ---------------------------------------------------------------------------
// tile_out_collector_if
// Bundle between a PE Tile result stream, the collector and the writeback
// consumer.
//   slave  : the collector's view (samples Tile results and consumer ready,
//            drives the buffered result stream and status).
//   master : the environment's view (Tile producer + writeback consumer).
// Signals:
//   io_in_c / io_in_propagate / io_in_valid : Tile result stream
//   io_out_bits / io_out_last / io_out_valid / io_out_ready : buffered output
//   io_count          : current FIFO occupancy
//   io_overflow       : sticky "a result was dropped" flag
//   io_clear_overflow : clears io_overflow
// ---------------------------------------------------------------------------
interface tile_out_collector_if #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [IN_W-1:0]  io_in_c;
  logic             io_in_propagate;
  logic             io_in_valid;
  logic [OUT_W-1:0] io_out_bits;
  logic             io_out_last;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [CW-1:0]    io_count;
  logic             io_overflow;
  logic             io_clear_overflow;

  modport master (
    output io_in_c, io_in_propagate, io_in_valid, io_out_ready, io_clear_overflow,
    input  io_out_bits, io_out_last, io_out_valid, io_count, io_overflow
  );

  modport slave (
    input  io_in_c, io_in_propagate, io_in_valid, io_out_ready, io_clear_overflow,
    output io_out_bits, io_out_last, io_out_valid, io_count, io_overflow
  );
endinterface

// File: rtl/tile_out_collector.sv
// ---------------------------------------------------------------------------
// tile_out_collector
// Captures a PE Tile's result stream, saturates each signed IN_W result to
// OUT_W, tags the last row of each ROWS-long matrix and buffers {last, data}
// in a DEPTH-entry FIFO read out over valid/ready. The Tile cannot be
// stalled, so a result arriving while the FIFO is full (and not draining)
// is dropped and recorded in a sticky overflow flag.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : tile_out_collector_if.slave (Tile input, output handshake,
//             occupancy, overflow status/clear)
// ---------------------------------------------------------------------------
module tile_out_collector #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 8,
  parameter int DEPTH = 8,
  parameter int ROWS  = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  tile_out_collector_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  // Saturation bounds expressed at the input width.
  localparam logic signed [IN_W-1:0] SAT_MAX =
    {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] SAT_MIN =
    {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [RW-1:0]   row_cnt_q, row_cnt_d;
  logic            prev_prop_q, prev_prop_d;
  logic            overflow_q, overflow_d;
  logic [OUT_W:0]  mem_q [DEPTH];

  // -------------------------------------------------------------------------
  // Saturation
  // -------------------------------------------------------------------------
  logic signed [IN_W-1:0] c_s;
  logic [OUT_W-1:0]       sat_c;

  assign c_s = $signed(bus.io_in_c);

  always_comb begin
    sat_c = bus.io_in_c[OUT_W-1:0];
    if (c_s > SAT_MAX) begin
      sat_c = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (c_s < SAT_MIN) begin
      sat_c = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  // -------------------------------------------------------------------------
  // Row tagging. A change of the propagate bit marks the start of a new
  // matrix. The tracker advances on every Tile valid, including dropped
  // results, so row alignment survives an overflow.
  // -------------------------------------------------------------------------
  logic [RW-1:0] row_idx;
  logic          row_last;

  assign row_idx  = (bus.io_in_propagate != prev_prop_q) ? '0 : row_cnt_q;
  assign row_last = (row_idx == RW'(ROWS - 1));

  always_comb begin
    row_cnt_d   = row_cnt_q;
    prev_prop_d = prev_prop_q;
    if (bus.io_in_valid) begin
      row_cnt_d   = row_last ? '0 : row_idx + RW'(1);
      prev_prop_d = bus.io_in_propagate;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  logic out_valid;
  logic full;
  logic deq;
  logic enq;
  logic drop;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  assign deq       = out_valid & bus.io_out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign enq       = bus.io_in_valid & (~full | deq);
  assign drop      = bus.io_in_valid & full & ~deq;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (enq) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Set takes priority over clear so a drop is never lost.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.io_clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      row_cnt_q   <= '0;
      prev_prop_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      row_cnt_q   <= row_cnt_d;
      prev_prop_q <= prev_prop_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage is not reset: zeroed pointers and count make old contents
  // unreachable, and the outputs are masked while empty.
  always_ff @(posedge clock) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= {row_last, sat_c};
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (all from registered state; io_out_ready only affects next state)
  // -------------------------------------------------------------------------
  logic [OUT_W:0] head;

  assign head             = mem_q[rd_ptr_q];
  assign bus.io_out_valid = out_valid;
  assign bus.io_out_bits  = out_valid ? head[OUT_W-1:0] : '0;
  assign bus.io_out_last  = out_valid ? head[OUT_W] : 1'b0;
  assign bus.io_count     = count_q;
  assign bus.io_overflow  = overflow_q;

endmodule

// File: tb/tb_tile_out_collector.sv
// ---------------------------------------------------------------------------
// Testbench for tile_out_collector (IN_W=19, OUT_W=8, DEPTH=8, ROWS=8).
// ---------------------------------------------------------------------------
module tb_tile_out_collector;

  localparam int IN_W  = 19;
  localparam int OUT_W = 8;
  localparam int DEPTH = 8;
  localparam int ROWS  = 8;

  logic clock;
  logic reset_n;

  tile_out_collector_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) ifc ();

  tile_out_collector #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ROWS(ROWS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] b;
    bit         l;
  } ent_t;

  ent_t mq[$];
  int   m_row;
  bit   m_prev;
  bit   m_ovf;

  function automatic logic [7:0] sat8(input logic [18:0] c);
    int v;
    v = int'($signed(c));
    if (v > 127) v = 127;
    else if (v < -128) v = -128;
    return v[7:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_row  = 0;
    m_prev = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // One clock edge of the collector, seen as matrix position bookkeeping
  // plus a bounded queue.
  task automatic model_edge(input logic [18:0] c, input bit p, input bit v,
                            input bit r, input bit clr);
    bit   deq;
    bit   full;
    int   idx;
    ent_t e;
    deq  = (mq.size() > 0) && r;
    full = (mq.size() == DEPTH);
    e.b  = '0;
    e.l  = 1'b0;
    if (v) begin
      idx    = (p != m_prev) ? 0 : m_row;
      e.b    = sat8(c);
      e.l    = (idx == ROWS - 1);
      m_row  = (idx + 1) % ROWS;
      m_prev = p;
    end
    if (deq) void'(mq.pop_front());
    if (v && (!full || deq)) mq.push_back(e);
    if (v && full && !deq) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("cnt",  int'(ifc.io_count), mq.size());
    chk("vld",  int'(ifc.io_out_valid), int'(mq.size() > 0));
    chk("bits", int'(ifc.io_out_bits), (mq.size() > 0) ? int'(mq[0].b) : 0);
    chk("last", int'(ifc.io_out_last), (mq.size() > 0) ? int'(mq[0].l) : 0);
    chk("ovf",  int'(ifc.io_overflow), int'(m_ovf));
  endtask

  // Drive inputs, take one edge, check 1 ns later.
  task automatic step(input logic [18:0] c, input bit p, input bit v,
                      input bit r, input bit clr);
    ifc.io_in_c           = c;
    ifc.io_in_propagate   = p;
    ifc.io_in_valid       = v;
    ifc.io_out_ready      = r;
    ifc.io_clear_overflow = clr;
    @(posedge clock);
    model_edge(c, p, v, r, clr);
    #1;
    compare_model();
    $display("t=%0t c=%h p=%0b v=%0b r=%0b clr=%0b | cnt=%0d vld=%0b out=%h last=%0b ovf=%0b",
             $time, c, p, v, r, clr, ifc.io_count, ifc.io_out_valid,
             ifc.io_out_bits, ifc.io_out_last, ifc.io_overflow);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    ifc.io_in_valid       = 1'b0;
    ifc.io_out_ready      = 1'b0;
    ifc.io_clear_overflow = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_vld", int'(ifc.io_out_valid), 0);
    chk("rst_cnt", int'(ifc.io_count), 0);
    chk("rst_ovf", int'(ifc.io_overflow), 0);
    #2 reset_n = 1'b1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [18:0] c;
    bit          p, v, r, clr;
    logic [7:0]  eb;
    bit          el, ev;
    int          ec;
    bit          eo;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // Saturation: push 5, 300, -300, -128 then drain.
    tbl[0] = '{19'd5,       0, 1, 0, 0, 8'h05, 0, 1, 1, 0};
    tbl[1] = '{19'd300,     0, 1, 0, 0, 8'h05, 0, 1, 2, 0};
    tbl[2] = '{19'h7FED4,   0, 1, 0, 0, 8'h05, 0, 1, 3, 0};
    tbl[3] = '{19'h7FF80,   0, 1, 0, 0, 8'h05, 0, 1, 4, 0};
    tbl[4] = '{19'd0,       0, 0, 1, 0, 8'h7F, 0, 1, 3, 0};
    tbl[5] = '{19'd0,       0, 0, 1, 0, 8'h80, 0, 1, 2, 0};
    tbl[6] = '{19'd0,       0, 0, 1, 0, 8'h80, 0, 1, 1, 0};
    tbl[7] = '{19'd0,       0, 0, 1, 0, 8'h00, 0, 0, 0, 0};

    reset_n               = 1'b0;
    ifc.io_in_c           = '0;
    ifc.io_in_propagate   = 1'b0;
    ifc.io_in_valid       = 1'b0;
    ifc.io_out_ready      = 1'b0;
    ifc.io_clear_overflow = 1'b0;
    model_reset();

    #3;
    chk("init_vld", int'(ifc.io_out_valid), 0);
    chk("init_cnt", int'(ifc.io_count), 0);
    chk("init_ovf", int'(ifc.io_overflow), 0);
    chk("init_bits", int'(ifc.io_out_bits), 0);
    #9 reset_n = 1'b1;
    @(posedge clock);
    #1;
    compare_model();

    // ---- table-driven saturation ----
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].c, tbl[i].p, tbl[i].v, tbl[i].r, tbl[i].clr);
      chk("tbl_bits", int'(ifc.io_out_bits), int'(tbl[i].eb));
      chk("tbl_last", int'(ifc.io_out_last), int'(tbl[i].el));
      chk("tbl_vld",  int'(ifc.io_out_valid), int'(tbl[i].ev));
      chk("tbl_cnt",  int'(ifc.io_count), tbl[i].ec);
      chk("tbl_ovf",  int'(ifc.io_overflow), int'(tbl[i].eo));
    end

    // ---- row tagging ----
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(19'(k), 0, 1, 1, 0);
      chk("t2_last_a", int'(ifc.io_out_last), int'(k == 8));
    end
    for (int k = 1; k <= 3; k++) begin
      step(19'(k), 0, 1, 1, 0);
      chk("t2_last_b", int'(ifc.io_out_last), 0);
    end
    for (int k = 1; k <= 8; k++) begin
      step(19'(k), 1, 1, 1, 0);
      chk("t2_last_c", int'(ifc.io_out_last), int'(k == 8));
    end
    step(19'd0, 1, 0, 1, 0);

    // ---- backpressure / overflow ----
    do_reset();
    for (int k = 1; k <= 9; k++) step(19'(k), 0, 1, 0, 0);
    chk("t3_cnt", int'(ifc.io_count), 8);
    chk("t3_ovf", int'(ifc.io_overflow), 1);
    for (int k = 1; k <= 8; k++) begin
      chk("t3_head", int'(ifc.io_out_bits), k);
      chk("t3_vld", int'(ifc.io_out_valid), 1);
      step(19'd0, 0, 0, 1, 0);
    end
    chk("t3_empty", int'(ifc.io_out_valid), 0);

    // ---- full with simultaneous enq+deq ----
    do_reset();
    for (int k = 1; k <= 8; k++) step(19'(k), 0, 1, 0, 0);
    step(19'd42, 0, 1, 1, 0);
    chk("t4_cnt", int'(ifc.io_count), 8);
    chk("t4_ovf", int'(ifc.io_overflow), 0);
    chk("t4_head", int'(ifc.io_out_bits), 2);
    for (int k = 2; k <= 9; k++) begin
      chk("t4_seq", int'(ifc.io_out_bits), (k == 9) ? 42 : k);
      step(19'd0, 0, 0, 1, 0);
    end
    chk("t4_empty", int'(ifc.io_out_valid), 0);

    // ---- reset mid-operation ----
    do_reset();
    for (int k = 1; k <= 5; k++) step(19'(10 + k), 0, 1, 0, 0);
    chk("t5_cnt_pre", int'(ifc.io_count), 5);
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(19'(k), 0, 1, 1, 0);
      chk("t5_last", int'(ifc.io_out_last), int'(k == 8));
    end

    // ---- clear vs set ----
    do_reset();
    for (int k = 1; k <= 8; k++) step(19'(k), 0, 1, 0, 0);
    step(19'd99, 0, 1, 0, 1);
    chk("t6_set_wins", int'(ifc.io_overflow), 1);
    chk("t6_cnt", int'(ifc.io_count), 8);
    step(19'd0, 0, 0, 0, 1);
    chk("t6_clear", int'(ifc.io_overflow), 0);

    // ---- randomized against the model ----
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [18:0] rc;
      bit rp, rv, rr, rclr;
      if (n == 200) do_reset();
      rc   = ($urandom_range(0, 1) == 0) ? 19'($urandom_range(0, 511)) - 19'd256
                                         : 19'($urandom);
      rp   = m_prev ^ ($urandom_range(0, 9) == 0);
      rv   = ($urandom_range(0, 9) < 7);
      rr   = ($urandom_range(0, 9) < ((n / 50) % 2 == 0 ? 3 : 7));
      rclr = ($urandom_range(0, 9) == 0);
      step(rc, rp, rv, rr, rclr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
